// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Fetch stage bus: instruction-memory handshake, decode handshake and redirect.
import fetch_pkg::*;

interface fetch_if;
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;
  logic            inst_valid;
  logic            inst_ready;
  logic [XLEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction buffer: synchronous FIFO of {pc, inst} entries with a one-cycle flush.
import fetch_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_wr;
  logic [AW-1:0]  r_rd;
  logic [AW:0]    r_count;
  logic           w_push;
  logic           w_pop;

  // A flush wins over any same-cycle push or pop.
  assign w_push = i_push && !i_flush;
  assign w_pop  = i_pop && (r_count != '0) && !i_flush;

  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + (AW+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_head  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding imem request, buffered words to decode, redirect flush.
import fetch_pkg::*;

module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  fetch_if.master bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_addr;

  logic            w_push;
  logic            w_pop;
  logic            w_valid;
  fetch_entry_t    w_head;
  fetch_entry_t    w_entry;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_count_after;
  logic [XLEN-1:0] w_redir_pc;
  logic [XLEN-1:0] w_next_pc;

  assign w_redir_pc    = align_word(bus.redirect_pc);
  assign w_next_pc     = r_fetch_pc + 32'd4;
  assign w_push        = (r_state == REQ) && bus.imem_ack && !bus.redirect_valid;
  assign w_pop         = w_valid && bus.inst_ready && !bus.redirect_valid;
  assign w_count_after = w_count + CW'(w_push) - CW'(w_pop);
  assign w_entry       = '{pc: r_fetch_pc, inst: bus.imem_rdata};

  // r_addr is the address presented to imem; it only diverges from r_fetch_pc
  // in DROP, where it still names the request being discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_fetch_pc <= RESET_PC;
      r_addr     <= RESET_PC;
    end else if (bus.redirect_valid) begin
      r_fetch_pc <= w_redir_pc;
      if (r_state == IDLE || bus.imem_ack) begin
        r_state <= REQ;
        r_addr  <= w_redir_pc;
      end else begin
        r_state <= DROP;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_count < CW'(FIFO_DEPTH)) r_state <= REQ;
        end
        REQ: begin
          if (bus.imem_ack) begin
            r_fetch_pc <= w_next_pc;
            r_addr     <= w_next_pc;
            r_state    <= (w_count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
          end
        end
        DROP: begin
          if (bus.imem_ack) begin
            r_state <= REQ;
            r_addr  <= r_fetch_pc;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_data  (w_entry),
    .i_pop   (w_pop),
    .o_valid (w_valid),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign bus.imem_req   = (r_state != IDLE);
  assign bus.imem_addr  = r_addr;
  assign bus.inst_valid = w_valid;
  assign bus.inst       = w_head.inst;
  assign bus.inst_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, wait states, redirects and reset.
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  fetch_if bus();

  fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, act, exp);
    end
  endtask

  task automatic exp_out(input string tag, input logic req, input logic [31:0] addr,
                         input logic vld, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, ".req"},   {31'd0, bus.imem_req},   {31'd0, req});
    chk({tag, ".addr"},  bus.imem_addr,           addr);
    chk({tag, ".valid"}, {31'd0, bus.inst_valid}, {31'd0, vld});
    chk({tag, ".pc"},    bus.inst_pc,             pc);
    chk({tag, ".inst"},  bus.inst,                ins);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst                = 1'b1;
    bus.imem_ack       = 1'b0;
    bus.imem_rdata     = 32'h0;
    bus.inst_ready     = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state and first request one cycle after reset release
    do_reset();
    exp_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    tick();
    exp_out("first_req", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    // Zero-wait ack, decode always ready: one instruction per cycle
    bus.inst_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.imem_ack   = 1'b1;
      bus.imem_rdata = 32'hA000_0000 + 32'(4 * i);
      tick();
      exp_out("stream", 1'b1, 32'(4 * (i + 1)), 1'b1, 32'(4 * i), 32'hA000_0000 + 32'(4 * i));
    end

    // Backpressure: two words buffered, request stalls, order preserved
    do_reset();
    tick();
    exp_out("bp_start", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0000;
    tick();
    exp_out("bp_push0", 1'b1, 32'h4, 1'b1, 32'h0, 32'hB000_0000);
    bus.imem_rdata = 32'hB000_0004;
    tick();
    exp_out("bp_full", 1'b0, 32'h8, 1'b1, 32'h0, 32'hB000_0000);
    tick();
    exp_out("bp_hold", 1'b0, 32'h8, 1'b1, 32'h0, 32'hB000_0000);
    bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
    tick();
    exp_out("bp_pop0", 1'b0, 32'h8, 1'b1, 32'h4, 32'hB000_0004);
    bus.inst_ready = 1'b0;
    tick();
    exp_out("bp_rereq", 1'b1, 32'h8, 1'b1, 32'h4, 32'hB000_0004);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hB000_0008;
    tick();
    exp_out("bp_push8", 1'b0, 32'hC, 1'b1, 32'h4, 32'hB000_0004);
    bus.imem_ack = 1'b0; bus.inst_ready = 1'b1;
    tick();
    exp_out("bp_pop4", 1'b0, 32'hC, 1'b1, 32'h8, 32'hB000_0008);
    tick();
    exp_out("bp_empty", 1'b1, 32'hC, 1'b0, 32'h0, 32'h0);

    // Ack delayed three cycles: request and address held, single push
    do_reset();
    bus.inst_ready = 1'b1;
    tick();
    exp_out("wait0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      exp_out($sformatf("wait%0d", i), 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    end
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hC000_0000;
    tick();
    exp_out("wait_ack", 1'b1, 32'h4, 1'b1, 32'h0, 32'hC000_0000);
    bus.imem_ack = 1'b0;
    tick();
    exp_out("wait_single", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0);

    // Redirect while request to 0x8 is outstanding: DROP, then fetch 0x100
    do_reset();
    bus.inst_ready = 1'b1;
    tick();
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hD000_0000;
    tick();
    exp_out("rd_push0", 1'b1, 32'h4, 1'b1, 32'h0, 32'hD000_0000);
    bus.imem_rdata = 32'hD000_0004;
    tick();
    exp_out("rd_push4", 1'b1, 32'h8, 1'b1, 32'h4, 32'hD000_0004);
    bus.imem_ack = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
    tick();
    exp_out("rd_drop", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    bus.redirect_valid = 1'b0;
    tick();
    exp_out("rd_drop_hold", 1'b1, 32'h8, 1'b0, 32'h0, 32'h0);
    bus.imem_ack = 1'b1; bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    exp_out("rd_discard", 1'b1, 32'h100, 1'b0, 32'h0, 32'h0);
    bus.imem_rdata = 32'hD000_0100;
    tick();
    exp_out("rd_new", 1'b1, 32'h104, 1'b1, 32'h100, 32'hD000_0100);

    // Redirect to unaligned 0x203 with same-cycle ack: data dropped, FIFO flushed
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h203; bus.imem_rdata = 32'hEEEE_EEEE;
    tick();
    exp_out("ra_flush", 1'b1, 32'h200, 1'b0, 32'h0, 32'h0);
    bus.redirect_valid = 1'b0; bus.imem_rdata = 32'hE000_0200;
    tick();
    exp_out("ra_new", 1'b1, 32'h204, 1'b1, 32'h200, 32'hE000_0200);

    // Fill the FIFO, then reset with a stray ack present
    bus.inst_ready = 1'b0; bus.imem_rdata = 32'hE000_0204;
    tick();
    exp_out("rs_full", 1'b0, 32'h208, 1'b1, 32'h200, 32'hE000_0200);
    rst = 1'b1;
    tick();
    exp_out("rs_reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    tick();
    exp_out("rs_stray", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
    bus.imem_ack = 1'b0;
    tick();
    exp_out("rs_nopush", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
